mem_burst_ctrl: RTL and testbench
=================================

Name: mem_burst_ctrl

Overview:
Burst access controller that sits directly upstream of the single-port 1024x32 synchronous memory and is its only master. Accepts one burst command (start address, length, direction) and turns it into single-word memory accesses, one per cycle. Write data streams in over a valid/ready interface. Read data is buffered in a small output FIFO with backpressure, so a stalled consumer never loses a word.

Parameters:
DEPTH, 1024, memory depth in words
WIDTH, 32, data width
ADDR_WIDTH, $clog2(DEPTH), memory address width
LEN_WIDTH, 4, burst length field width; beats = cmd_len+1 (1..16)
FIFO_DEPTH, 4, read-data FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset
cmd_valid  input  1  burst command valid
cmd_ready  output  1  controller idle, command accepted when valid&ready
cmd_write  input  1  1=write burst, 0=read burst
cmd_addr  input  ADDR_WIDTH  start word address
cmd_len  input  LEN_WIDTH  beats minus one
wr_valid  input  1  write data valid
wr_ready  output  1  write data accepted when valid&ready
wr_data  input  WIDTH  write data beat
rd_valid  output  1  FIFO head valid
rd_ready  input  1  consumer accepts head
rd_data  output  WIDTH  FIFO head data
done  output  1  one-cycle pulse when burst completes
mem_valid  output  1  memory access strobe
mem_rw_en  output  1  1=write, 0=read
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  WIDTH  memory write data
mem_ready  input  1  memory ready (high the cycle after a sampled access)
mem_rdata  input  WIDTH  memory read data (registered in memory, valid the cycle after a read is sampled)

Behaviour:
- Reset rst, synchronous, active-high; clock clk. Reset aborts any burst and flushes the FIFO and outstanding counters. After reset, all outputs are 0 except cmd_ready=1.
- All mem_* outputs are registered. mem_valid is 0 on every cycle where no access is issued. mem_wdata holds its last value when idle.
- FSM states: IDLE, WRITE, READ, RD_DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, latch addr, beat count = cmd_len+1 and direction, then go to WRITE or READ. cmd_ready is 0 in all other states.
- WRITE: wr_ready=1.
  - Each wr_valid&wr_ready beat registers mem_valid=1, mem_rw_en=1, mem_addr=cur_addr, mem_wdata=wr_data for the next cycle. Then cur_addr increments and the remaining count decrements.
  - A gap in wr_valid gives mem_valid=0 that cycle.
  - On the last beat, wr_ready drops the next cycle, done pulses in the cycle the last write is on the bus, and the FSM returns to IDLE.
- READ: issue one read (mem_valid=1, mem_rw_en=0, mem_addr=cur_addr) per cycle only when fifo_count + outstanding < FIFO_DEPTH.
  - outstanding = reads issued but not yet pushed (max 2).
  - A read sampled by the memory at edge N has its data pushed into the FIFO at edge N+1, qualified by mem_ready.
  - After the last issue, go to RD_DRAIN.
- RD_DRAIN: wait for outstanding==0, pulse done, return to IDLE. done does not wait for the FIFO to empty. A new command may start while the FIFO still holds data.
- Address arithmetic is modulo DEPTH: 0x3FF+1 wraps to 0x000.
- FIFO push and pop in the same cycle is legal and leaves the count unchanged.
  - rd_valid = count!=0; rd_data shows the head (first-word-fall-through).
  - Pop when rd_valid&rd_ready.
  - With no pop, the FIFO never overflows because of the credit rule.
- Throughput: one word per cycle for writes (wr_valid held high) and for reads (rd_ready held high).
- Read latency: first rd_valid appears 3 cycles after the cmd handshake edge.
- Simultaneous cmd_valid and wr_valid in IDLE: wr_data is not accepted until the state is WRITE.
- Reset asserted mid-burst: mem_valid=0 the next cycle, the burst is discarded and no done pulse is issued.

Test Plan:
- Write burst cmd_addr=0x010, cmd_len=3, wr_data 0xA0..0xA3 back-to-back -> mem_valid high 4 consecutive cycles at addr 0x010..0x013 with mem_rw_en=1, single done pulse. Then read the same burst -> rd_data 0xA0,0xA1,0xA2,0xA3 in order.
- Read burst cmd_len=15 with rd_ready=0 -> exactly 4 reads issued and mem_valid stays 0 with 4 entries held. Release rd_ready -> all 16 words delivered in order, none dropped or duplicated.
- Wrap: write then read at cmd_addr=0x3FE, cmd_len=3 -> mem_addr sequence 0x3FE,0x3FF,0x000,0x001.
- Write burst with wr_valid toggling 1,0,1,0 -> mem_valid mirrors the accepted beats one cycle later. cmd_valid asserted during the burst sees cmd_ready=0 until done.
- Reset after 2 of 8 read beats -> next cycle mem_valid=0, rd_valid=0, cmd_ready=1, no done pulse. A new read burst after reset completes normally.
- Single-beat bursts (cmd_len=0) issued back-to-back -> one memory access each, done after each, cmd_ready returns high within 1 cycle of done.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// Burst controller for a single-port synchronous memory: turns one burst command
// into per-cycle word accesses and buffers read data in a small FWFT FIFO.
module mem_burst_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  done,
  output logic                  mem_valid,
  output logic                  mem_rw_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic                  mem_ready,
  input  logic [WIDTH-1:0]      mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] FIFO_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    READ     = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  state_t                state_r, state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr_r;
  logic [LEN_WIDTH:0]    remain_r;
  logic [1:0]            outstanding_r, outstanding_nx;
  logic                  rd_pend_r;
  logic [WIDTH-1:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_r, rptr_r;
  logic [CNT_W-1:0]      fifo_count_r;
  logic                  cmd_acc_s, wbeat_s, rissue_s, done_s, last_s;
  logic                  credit_ok_s, push_s, pop_s;

  assign cmd_ready   = (state_r == IDLE);
  assign wr_ready    = (state_r == WRITE);
  assign rd_valid    = (fifo_count_r != {CNT_W{1'b0}});
  assign rd_data     = rd_valid ? fifo_mem_r[rptr_r] : {WIDTH{1'b0}};
  assign pop_s       = rd_valid & rd_ready;
  // A read seen by the memory last cycle returns its word now.
  assign push_s      = rd_pend_r & mem_ready;
  assign last_s      = (remain_r == {{LEN_WIDTH{1'b0}}, 1'b1});
  // Credit: never issue a read that could find no FIFO slot.
  assign credit_ok_s = (({1'b0, fifo_count_r} + (CNT_W + 1)'(outstanding_r)) < FIFO_LIM);

  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  always_comb begin
    state_nx  = state_r;
    cmd_acc_s = 1'b0;
    wbeat_s   = 1'b0;
    rissue_s  = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          cmd_acc_s = 1'b1;
          state_nx  = cmd_write ? WRITE : READ;
        end else begin
          state_nx  = IDLE;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          wbeat_s = 1'b1;
          if (last_s) begin
            done_s   = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = WRITE;
          end
        end else begin
          state_nx = WRITE;
        end
      end
      READ: begin
        if (credit_ok_s) begin
          rissue_s = 1'b1;
          state_nx = last_s ? RD_DRAIN : READ;
        end else begin
          state_nx = READ;
        end
      end
      RD_DRAIN: begin
        if ((outstanding_r == 2'd0) || ((outstanding_r == 2'd1) && push_s)) begin
          done_s   = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = RD_DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case ({rissue_s, push_s})
      2'b10:   outstanding_nx = outstanding_r + 2'd1;
      2'b01:   outstanding_nx = outstanding_r - 2'd1;
      default: outstanding_nx = outstanding_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_r    <= {ADDR_WIDTH{1'b0}};
      remain_r      <= {(LEN_WIDTH + 1){1'b0}};
      outstanding_r <= 2'd0;
      rd_pend_r     <= 1'b0;
      done          <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rw_en     <= 1'b0;
      mem_addr      <= {ADDR_WIDTH{1'b0}};
      mem_wdata     <= {WIDTH{1'b0}};
    end else begin
      done          <= done_s;
      mem_valid     <= wbeat_s | rissue_s;
      outstanding_r <= outstanding_nx;
      rd_pend_r     <= mem_valid & ~mem_rw_en;
      if (cmd_acc_s) begin
        cur_addr_r <= cmd_addr;
        remain_r   <= {1'b0, cmd_len} + {{LEN_WIDTH{1'b0}}, 1'b1};
      end else if (wbeat_s | rissue_s) begin
        // Power-of-two depth: natural overflow gives the modulo wrap.
        cur_addr_r <= cur_addr_r + {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};
        remain_r   <= remain_r - {{LEN_WIDTH{1'b0}}, 1'b1};
      end
      if (wbeat_s | rissue_s) begin
        mem_rw_en <= wbeat_s;
        mem_addr  <= cur_addr_r;
      end
      if (wbeat_s) mem_wdata <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r       <= {PTR_W{1'b0}};
      rptr_r       <= {PTR_W{1'b0}};
      fifo_count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wptr_r] <= mem_rdata;
        wptr_r             <= wptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
      end
      if (pop_s) rptr_r <= rptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + {{(CNT_W - 1){1'b0}}, 1'b1};
        2'b01:   fifo_count_r <= fifo_count_r - {{(CNT_W - 1){1'b0}}, 1'b1};
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: a behavioural memory, a reference image of
// memory contents and expected access / read-data queues built from burst arithmetic.
module tb_mem_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done;
  logic        mem_valid, mem_rw_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  mem_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done),
    .mem_valid(mem_valid), .mem_rw_en(mem_rw_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural 1024x32 synchronous memory
  logic [31:0] mem_arr [1024];
  always @(posedge clk) begin
    mem_ready <= mem_valid;
    if (mem_valid) begin
      if (mem_rw_en) mem_arr[mem_addr] <= mem_wdata;
      else           mem_rdata <= mem_arr[mem_addr];
    end
  end

  logic [31:0] ref_mem [1024];
  logic [42:0] exp_acc [$];
  logic [31:0] exp_rd [$];
  logic [31:0] wr_src [$];
  int checks = 0, failures = 0;
  int done_cnt, run, max_run, rd_issued, busy_err;
  bit busy, hold_cmd, hs_cmd, hs_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic cyc();
    logic [42:0] e;
    @(negedge clk);
    hs_cmd = cmd_valid & cmd_ready;
    hs_wr  = wr_valid & wr_ready;
    if (mem_valid) begin
      run++;
      if (run > max_run) max_run = run;
      if (!mem_rw_en) rd_issued++;
      if (exp_acc.size() == 0) begin
        check("acc_spurious", {53'd0, mem_rw_en, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_acc.pop_front();
        check("acc_rw", 64'(mem_rw_en), 64'(e[42]));
        check("acc_addr", 64'(mem_addr), 64'(e[41:32]));
        if (e[42]) check("acc_wdata", 64'(mem_wdata), 64'(e[31:0]));
      end
    end else begin
      run = 0;
    end
    if (done) begin
      done_cnt++;
      check("done_cmd_ready", 64'(cmd_ready), 64'd1);
      busy = 1'b0;
      if (hold_cmd) cmd_valid = 1'b0;
    end else if (busy && cmd_ready) begin
      busy_err++;
    end
    if (rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) check("rd_spurious", 64'(rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else                    check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_hs(input bit wr, input int addr, input int len);
    int n = 0;
    cmd_write = wr; cmd_addr = 10'(addr); cmd_len = 4'(len); cmd_valid = 1'b1;
    hs_cmd = 1'b0;
    while (!hs_cmd && n < 50) begin cyc(); n++; end
    check("cmd_handshake", 64'(hs_cmd), 64'd1);
    cmd_valid = hold_cmd;
    busy = 1'b1;
  endtask

  // gap: 0 = wr_valid held high, 1 = alternating 1,0,1,0, 2 = random
  task automatic do_write(input int addr, input int len, input int gap);
    int k = 0, t = 0;
    for (int i = 0; i <= len; i++) begin
      exp_acc.push_back({1'b1, 10'((addr + i) % 1024), wr_src[i]});
      ref_mem[(addr + i) % 1024] = wr_src[i];
    end
    done_cnt = 0; busy_err = 0; max_run = 0;
    wr_valid = 1'b1; wr_data = wr_src[0];
    cmd_hs(1'b1, addr, len);
    while (k <= len && t < 200) begin
      case (gap)
        0:       wr_valid = 1'b1;
        1:       wr_valid = (t % 2 == 0);
        default: wr_valid = 1'($urandom_range(0, 1));
      endcase
      wr_data = wr_valid ? wr_src[k] : $urandom;
      cyc();
      if (hs_wr) k++;
      t++;
    end
    wr_valid = 1'b0;
    check("wr_beats", 64'(k), 64'(len + 1));
    check("wr_last_on_bus", {61'd0, done, mem_valid, wr_ready}, 64'b110);
    for (int i = 0; i < 3; i++) cyc();
    check("wr_done_count", 64'(done_cnt), 64'd1);
    check("wr_acc_left", 64'(exp_acc.size()), 64'd0);
    check("wr_cmd_ready_busy", 64'(busy_err), 64'd0);
    if (gap == 0) check("wr_throughput", 64'(max_run), 64'(len + 1));
    if (gap == 1) check("wr_gap_mirror", 64'(max_run), 64'd1);
    cmd_valid = 1'b0; busy = 1'b0;
    wr_src.delete();
  endtask

  // mode: 0 = rd_ready held high, 1 = random, 2 = stalled 12 cycles then released
  task automatic do_read(input int addr, input int len, input int mode);
    int t = 0, first = -1;
    for (int i = 0; i <= len; i++) begin
      exp_acc.push_back({1'b0, 10'((addr + i) % 1024), 32'h0});
      exp_rd.push_back(ref_mem[(addr + i) % 1024]);
    end
    done_cnt = 0; busy_err = 0; max_run = 0; rd_issued = 0;
    rd_ready = (mode == 0);
    cmd_hs(1'b0, addr, len);
    while ((done_cnt == 0 || exp_rd.size() != 0) && t < 300) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = (t >= 12);
      endcase
      if (mode == 2 && t == 12) begin
        check("stall_issued", 64'(rd_issued), 64'd4);
        check("stall_mem_idle", 64'(mem_valid), 64'd0);
        check("stall_rd_valid", 64'(rd_valid), 64'd1);
      end
      cyc();
      t++;
      if (first < 0 && rd_valid) first = t;
    end
    rd_ready = 1'b0;
    cyc(); cyc();
    check("rd_latency", 64'(first), 64'd3);
    check("rd_left", 64'(exp_rd.size()), 64'd0);
    check("rd_acc_left", 64'(exp_acc.size()), 64'd0);
    check("rd_done_count", 64'(done_cnt), 64'd1);
    check("rd_cmd_ready_busy", 64'(busy_err), 64'd0);
    if (mode == 0) check("rd_throughput", 64'(max_run), 64'(len + 1));
    busy = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 10'h0; cmd_len = 4'h0;
    wr_valid = 1'b0; wr_data = 32'h0; rd_ready = 1'b0;
    hold_cmd = 1'b0; busy = 1'b0; done_cnt = 0; run = 0; max_run = 0; rd_issued = 0; busy_err = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_outs", {58'd0, wr_ready, rd_valid, done, mem_valid, mem_rw_en, 1'b0}, 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);

    // Back-to-back write then read of the same burst
    for (int i = 0; i < 4; i++) wr_src.push_back(32'hA0 + 32'(i));
    do_write(32'h010, 3, 0);
    do_read(32'h010, 3, 0);

    // Full-length burst, read with a stalled consumer
    for (int i = 0; i < 16; i++) wr_src.push_back($urandom);
    do_write(32'h020, 15, 0);
    do_read(32'h020, 15, 2);

    // Address wrap at the top of memory
    for (int i = 0; i < 4; i++) wr_src.push_back($urandom);
    do_write(32'h3FE, 3, 0);
    do_read(32'h3FE, 3, 0);

    // Gapped write with a competing command held during the burst
    for (int i = 0; i < 4; i++) wr_src.push_back($urandom);
    hold_cmd = 1'b1;
    do_write(32'h040, 3, 1);
    hold_cmd = 1'b0;
    do_read(32'h040, 3, 1);

    // Reset in the middle of a read burst
    for (int i = 0; i < 8; i++) begin
      exp_acc.push_back({1'b0, 10'(32'h100 + i), 32'h0});
      exp_rd.push_back(ref_mem[32'h100 + i]);
    end
    done_cnt = 0; rd_issued = 0; rd_ready = 1'b0;
    cmd_hs(1'b0, 32'h100, 7);
    for (int n = 0; n < 20 && rd_issued < 2; n++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_mem_valid", 64'(mem_valid), 64'd0);
    check("midrst_rd_valid", 64'(rd_valid), 64'd0);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    exp_acc.delete(); exp_rd.delete(); busy = 1'b0; done_cnt = 0;
    for (int i = 0; i < 4; i++) cyc();
    check("midrst_late_rd_valid", 64'(rd_valid), 64'd0);
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    do_read(32'h010, 3, 0);

    // Single-beat bursts back to back
    for (int i = 0; i < 4; i++) begin
      wr_src.push_back($urandom);
      do_write(32'h200 + i, 0, 0);
      do_read(32'h200 + i, 0, 0);
    end

    // Randomized bursts against the reference image
    for (int n = 0; n < 24; n++) begin
      int a, l;
      a = $urandom_range(0, 1023);
      l = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= l; i++) wr_src.push_back($urandom);
        do_write(a, l, 2);
      end else begin
        do_read(a, l, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
